// File: rtl/mem_access.sv
// mem_access: EX/MEM pipeline register, data-memory req/ack handshake and load formatting.
// Optional feature macro MEM_SUBWORD_EN: when defined, byte/halfword loads and stores are
// supported; otherwise every access is a full word and funct3 is ignored.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_e,
  input  logic [1:0]  result_src_e,
  input  logic        mem_write_e,
  input  logic        mem_read_e,
  input  logic [2:0]  funct3_e,
  input  logic [31:0] alu_result_e,
  input  logic [31:0] write_data_e,
  input  logic [4:0]  rd_e,
  input  logic [31:0] pc_plus4_e,
  input  logic        flush_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_m,
  output logic        misalign_m,
  output logic        reg_write_m,
  output logic [1:0]  result_src_m,
  output logic [4:0]  rd_m,
  output logic [31:0] alu_result_m,
  output logic [31:0] pc_plus4_m,
  output logic [31:0] read_data_m
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  r_state;
  logic        r_reg_write;
  logic [1:0]  r_result_src;
  logic        r_mem_write;
  logic        r_mem_read;
  logic [2:0]  r_funct3;
  logic [31:0] r_alu_result;
  logic [31:0] r_write_data;
  logic [4:0]  r_rd;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_read_data;

  logic        w_mis_e;
  logic        w_mis_m;
  logic        w_go_e;
  logic [3:0]  w_store_be;
  logic [31:0] w_store_data;
  logic [31:0] w_load_data;

`ifdef MEM_SUBWORD_EN
  logic [15:0] w_lane;
  assign w_mis_e = (funct3_e[1:0] == 2'b00) ? 1'b0 :
                   (funct3_e[1:0] == 2'b01) ? alu_result_e[0] : |alu_result_e[1:0];
  assign w_mis_m = (r_funct3[1:0] == 2'b00) ? 1'b0 :
                   (r_funct3[1:0] == 2'b01) ? r_alu_result[0] : |r_alu_result[1:0];
  assign w_lane = 16'(mem_rdata >> {r_alu_result[1:0], 3'b000});
  // Lane enables/replicated data for stores, lane extraction plus sign/zero extension for loads
  always_comb begin
    w_store_be   = (r_funct3[1:0] == 2'b00) ? 4'b0001 << r_alu_result[1:0] :
                   (r_funct3[1:0] == 2'b01) ? 4'b0011 << r_alu_result[1:0] : 4'hF;
    w_store_data = (r_funct3[1:0] == 2'b00) ? {4{r_write_data[7:0]}} :
                   (r_funct3[1:0] == 2'b01) ? {2{r_write_data[15:0]}} : r_write_data;
    w_load_data  = (r_funct3[1:0] == 2'b00) ? {{24{~r_funct3[2] & w_lane[7]}}, w_lane[7:0]} :
                   (r_funct3[1:0] == 2'b01) ? {{16{~r_funct3[2] & w_lane[15]}}, w_lane[15:0]} :
                   mem_rdata;
  end
`else
  logic w_unused_f3;
  assign w_unused_f3 = ^r_funct3;
  assign w_mis_e     = |alu_result_e[1:0];
  assign w_mis_m     = |r_alu_result[1:0];
  // Word-only build: data passes straight through with all byte lanes enabled
  always_comb begin
    w_store_be   = 4'hF;
    w_store_data = r_write_data;
    w_load_data  = mem_rdata;
  end
`endif

  assign w_go_e       = (mem_read_e | mem_write_e) & ~w_mis_e & ~flush_m;
  assign mem_req      = (r_state == REQ);
  assign stall_m      = mem_req;
  assign mem_we       = mem_req & r_mem_write;
  assign mem_addr     = {r_alu_result[31:2], 2'b00};
  assign mem_be       = r_mem_read ? 4'hF : r_mem_write ? w_store_be : 4'h0;
  assign mem_wdata    = r_mem_write ? w_store_data : 32'h0;
  assign misalign_m   = (r_mem_read | r_mem_write) & w_mis_m;
  assign reg_write_m  = r_reg_write & ~misalign_m;
  assign result_src_m = r_result_src;
  assign rd_m         = r_rd;
  assign alu_result_m = r_alu_result;
  assign pc_plus4_m   = r_pc_plus4;
  assign read_data_m  = r_read_data;

  // EX/MEM register: loads on every unstalled edge, a flush loads an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 2'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_funct3     <= 3'b0;
      r_alu_result <= 32'h0;
      r_write_data <= 32'h0;
      r_rd         <= 5'h0;
      r_pc_plus4   <= 32'h0;
    end else if (!stall_m) begin
      r_reg_write  <= flush_m ? 1'b0  : reg_write_e;
      r_result_src <= flush_m ? 2'b0  : result_src_e;
      r_mem_write  <= flush_m ? 1'b0  : mem_write_e;
      r_mem_read   <= flush_m ? 1'b0  : mem_read_e;
      r_funct3     <= flush_m ? 3'b0  : funct3_e;
      r_alu_result <= flush_m ? 32'h0 : alu_result_e;
      r_write_data <= flush_m ? 32'h0 : write_data_e;
      r_rd         <= flush_m ? 5'h0  : rd_e;
      r_pc_plus4   <= flush_m ? 32'h0 : pc_plus4_e;
    end
  end

  // Handshake FSM: an aligned memory op enters REQ and stays there until acknowledged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else if (!stall_m) r_state <= w_go_e ? REQ : IDLE;
    else if (mem_ack) r_state <= DONE;
  end

  // Load result: cleared when a new instruction enters, captured on the acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_read_data <= 32'h0;
    else if (!stall_m) r_read_data <= 32'h0;
    else if (mem_ack) r_read_data <= w_load_data;
  end
endmodule
